sec_cnt_ctrl: RTL and testbench

// Command-driven sequencer for the 17-bit seconds-of-day up/down counter. Generates the
// 1 Hz advance pulses from a prescaler. Drives load/mode strobes and watches the fed-back count.

---
 rtl/sec_cnt_ctrl.sv | 149 ++++++++++++++
 tb/tb_sec_cnt_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sec_cnt_ctrl.sv
// Command sequencer for the seconds-of-day counter: prescales cnt_clk into 1 Hz
// ticks and turns them into registered up/down/load strobes for the counter.
module sec_cnt_ctrl #(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 17,
  parameter int DAY_MAX  = 86400
) (
  input  logic             cnt_clk,
  input  logic             cnt_rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] count_in,
  output logic             up_pulse,
  output logic             down_pulse,
  output logic             load_pulse,
  output logic             load_en,
  output logic             tick,
  output logic             expired,
  output logic             day_wrap,
  output logic             cmd_err,
  output logic [2:0]       state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DAY_MAX);

  localparam logic [1:0] OP_START_UP   = 2'b00;
  localparam logic [1:0] OP_START_DOWN = 2'b01;
  localparam logic [1:0] OP_STOP       = 2'b10;
  localparam logic [1:0] OP_RESUME     = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN_UP   = 3'd2,
    RUN_DOWN = 3'd3,
    PAUSED   = 3'd4
  } st_t;

  st_t           st, st_nxt;
  logic          dir_dn, dir_dn_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          acc, at_tick, expire;
  logic          up_nxt, dn_nxt, tick_nxt, exp_nxt, wrap_nxt, err_nxt;

  assign acc = cmd_valid & cmd_ready;

  always_comb begin
    st_nxt     = st;
    dir_dn_nxt = dir_dn;
    presc_nxt  = presc;
    up_nxt     = 1'b0;
    dn_nxt     = 1'b0;
    tick_nxt   = 1'b0;
    exp_nxt    = 1'b0;
    wrap_nxt   = 1'b0;
    err_nxt    = 1'b0;
    at_tick    = 1'b0;
    expire     = 1'b0;
    case (st)
      IDLE: if (acc) begin
        case (cmd_op)
          OP_START_UP:   begin st_nxt = RUN_UP; dir_dn_nxt = 1'b0; presc_nxt = '0; end
          OP_START_DOWN: begin st_nxt = LOAD;   dir_dn_nxt = 1'b1; end
          default:       err_nxt = 1'b1;
        endcase
      end
      LOAD: begin
        st_nxt    = RUN_DOWN;
        presc_nxt = '0;
      end
      RUN_UP, RUN_DOWN: begin
        at_tick   = (presc == PRESC_LAST);
        presc_nxt = at_tick ? '0 : presc + PW'(1);
        if (at_tick) begin
          tick_nxt = 1'b1;
          if (st == RUN_UP) begin
            up_nxt   = 1'b1;
            wrap_nxt = (count_in == CNT_MAX);
          end else if (count_in == '0) begin
            expire     = 1'b1;
            exp_nxt    = 1'b1;
            st_nxt     = IDLE;
            dir_dn_nxt = 1'b0;
          end else begin
            dn_nxt = 1'b1;
          end
        end
        // Expiry outranks a coincident STOP: the run is already over.
        if (acc) begin
          if (cmd_op == OP_STOP) begin
            if (!expire) st_nxt = PAUSED;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      PAUSED: if (acc) begin
        case (cmd_op)
          OP_RESUME:     st_nxt = dir_dn ? RUN_DOWN : RUN_UP;
          OP_STOP:       begin st_nxt = IDLE;   dir_dn_nxt = 1'b0; end
          OP_START_UP:   begin st_nxt = RUN_UP; dir_dn_nxt = 1'b0; presc_nxt = '0; end
          OP_START_DOWN: begin st_nxt = LOAD;   dir_dn_nxt = 1'b1; end
          default:       err_nxt = 1'b1;
        endcase
      end
      default: begin
        st_nxt     = IDLE;
        dir_dn_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cnt_clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      st         <= IDLE;
      dir_dn     <= 1'b0;
      presc      <= '0;
      cmd_ready  <= 1'b1;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      load_pulse <= 1'b0;
      load_en    <= 1'b0;
      tick       <= 1'b0;
      expired    <= 1'b0;
      day_wrap   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      st         <= st_nxt;
      dir_dn     <= dir_dn_nxt;
      presc      <= presc_nxt;
      cmd_ready  <= (st_nxt != LOAD);
      up_pulse   <= up_nxt;
      down_pulse <= dn_nxt;
      load_pulse <= (st_nxt == LOAD);
      load_en    <= (st_nxt == LOAD) || (st_nxt == RUN_DOWN) ||
                    ((st_nxt == PAUSED) && dir_dn_nxt);
      tick       <= tick_nxt;
      expired    <= exp_nxt;
      day_wrap   <= wrap_nxt;
      cmd_err    <= err_nxt;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_sec_cnt_ctrl.sv
// Bench for sec_cnt_ctrl at TICK_DIV=4: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_sec_cnt_ctrl;
  localparam int TD  = 4;
  localparam int DMX = 86400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [16:0] count_in = '0;
  logic        cmd_ready, up_pulse, down_pulse, load_pulse, load_en;
  logic        tick, expired, day_wrap, cmd_err;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  sec_cnt_ctrl #(.TICK_DIV(TD), .CNT_W(17), .DAY_MAX(DMX)) dut (
    .cnt_clk(clk), .cnt_rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .count_in(count_in), .up_pulse(up_pulse),
    .down_pulse(down_pulse), .load_pulse(load_pulse), .load_en(load_en),
    .tick(tick), .expired(expired), .day_wrap(day_wrap), .cmd_err(cmd_err),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] outs();
    return {cmd_ready, up_pulse, down_pulse, load_pulse, load_en, tick,
            expired, day_wrap, cmd_err, state};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode name, remembered direction, and number of
  // running edges since the last prescaler clear.
  int m_mode;   // 0 idle, 1 load, 2 up, 3 down, 4 paused
  bit m_down;
  int m_runs;
  logic [11:0] m_exp;

  task automatic model_reset();
    m_mode = 0; m_down = 0; m_runs = 0;
    m_exp = 12'h800;
  endtask

  task automatic model_step();
    bit acc, tk, up, dn, ex, wr, er;
    acc = cmd_valid && (m_mode != 1);
    tk = 0; up = 0; dn = 0; ex = 0; wr = 0; er = 0;
    case (m_mode)
      0: if (acc) begin
        if (cmd_op == 0) begin m_mode = 2; m_down = 0; m_runs = 0; end
        else if (cmd_op == 1) begin m_mode = 1; m_down = 1; end
        else er = 1;
      end
      1: begin m_mode = 3; m_runs = 0; end
      2, 3: begin
        m_runs++;
        tk = (m_runs % TD) == 0;
        if (tk && m_mode == 2) begin up = 1; wr = (count_in == DMX); end
        if (tk && m_mode == 3) begin
          if (count_in == 0) begin ex = 1; m_mode = 0; m_down = 0; end
          else dn = 1;
        end
        if (acc) begin
          if (cmd_op == 2) begin if (!ex) m_mode = 4; end
          else er = 1;
        end
      end
      4: if (acc) begin
        case (cmd_op)
          2'd3: m_mode = m_down ? 3 : 2;
          2'd2: begin m_mode = 0; m_down = 0; end
          2'd0: begin m_mode = 2; m_down = 0; m_runs = 0; end
          default: begin m_mode = 1; m_down = 1; end
        endcase
      end
      default: ;
    endcase
    m_exp = {(m_mode != 1), up, dn, (m_mode == 1),
             (m_mode == 1 || m_mode == 3 || (m_mode == 4 && m_down)),
             tk, ex, wr, er, 3'(m_mode)};
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("model", 32'(outs()), 32'(m_exp));
  end

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] op);
    cmd_valid = 1'b1; cmd_op = op;
    edge1();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [16:0] vu, vd, vl, ve, vx;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    edge1();

    // idle after reset: nothing moves for 20 cycles
    vx = '0;
    for (int k = 0; k < 20; k++) begin
      if (outs() !== 12'h800) vx[0] = 1'b1;
      edge1();
    end
    chk("idle_quiet", 32'(vx[0]), 32'd0);

    // START_UP: ticks after edges 4, 8, 12
    vu = '0; vl = '0; ve = '0;
    cmd_valid = 1'b1; cmd_op = 2'd0;
    for (int k = 0; k <= 12; k++) begin
      edge1();
      if (k == 0) cmd_valid = 1'b0;
      vu[k] = up_pulse; ve[k] = tick; vl[k] = load_en;
    end
    chk("up_pulse_edges", 32'(vu), 32'h1110);
    chk("up_tick_edges", 32'(ve), 32'h1110);
    chk("up_load_en", 32'(vl), 32'h0);
    send(2'd2); send(2'd2);
    chk("abort_idle", 32'(state), 32'd0);

    // START_DOWN: load after edge 0, down after 5 and 9, expiry at 13
    count_in = 17'd5;
    vu = '0; vd = '0; vl = '0; ve = '0;
    cmd_valid = 1'b1; cmd_op = 2'd1;
    for (int k = 0; k <= 13; k++) begin
      edge1();
      if (k == 0) cmd_valid = 1'b0;
      if (k == 9) count_in = '0;
      vl[k] = load_pulse; vd[k] = down_pulse; ve[k] = load_en; vu[k] = expired;
    end
    chk("down_load_pulse", 32'(vl), 32'h0001);
    chk("down_pulse_edges", 32'(vd), 32'h0220);
    chk("down_load_en", 32'(ve), 32'h1FFF);
    chk("down_expired", 32'(vu), 32'h2000);
    chk("expired_state", 32'(state), 32'd0);

    // pause/resume keeps the prescaler: next pulse after edge 14
    vu = '0;
    cmd_valid = 1'b1; cmd_op = 2'd0;
    for (int k = 0; k <= 16; k++) begin
      edge1();
      cmd_valid = 1'b0;
      if (k == 1)  begin cmd_valid = 1'b1; cmd_op = 2'd2; end
      if (k == 11) begin cmd_valid = 1'b1; cmd_op = 2'd3; end
      vu[k] = up_pulse;
    end
    chk("resume_pulse", 32'(vu), 32'h04000);
    send(2'd2); send(2'd2);

    // day wrap at terminal count
    count_in = 17'(DMX);
    send(2'd0);
    repeat (4) edge1();
    chk("wrap_up", 32'({up_pulse, day_wrap, state}), 32'({2'b11, 3'd2}));
    send(2'd2); send(2'd2);

    // illegal START_UP during RUN_DOWN, then async reset mid-run
    count_in = 17'd100;
    send(2'd1);
    repeat (3) edge1();
    send(2'd0);
    chk("err_in_down", 32'({cmd_err, state}), 32'({1'b1, 3'd3}));
    edge1();
    chk("err_one_cycle", 32'({cmd_err, state}), 32'({1'b0, 3'd3}));
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 32'(outs()), 32'h800);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // randomized run
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: count_in = '0;
        1: count_in = 17'(DMX);
        default: count_in = 17'($urandom_range(0, 131071));
      endcase
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    edge1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
